// File: rtl/vis_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// vis_prefetch_pkg
// Shared definitions for the visibilities prefetch master:
//   - default geometry of a correlator bank (word width, slots, address bits)
//   - drain FSM state encoding
//   - bank synchroniser depth
// ---------------------------------------------------------------------------
package vis_prefetch_pkg;

  // Default correlator geometry
  localparam int DEF_ACCUM = 24;   // visibility word width
  localparam int DEF_TRATE = 12;   // time-multiplexed slots per bank
  localparam int DEF_TBITS = 4;    // slot address bits
  localparam int DEF_BBITS = 4;    // bank counter bits
  localparam int DEF_WBITS = 7;    // readback buffer word index bits
  localparam int DEF_TMOUT = 15;   // ack timeout in bus cycles

  // Each slot carries eight visibility words, addressed by a 3-bit select
  localparam int SEL_BITS = 3;

  // Depth of the bank_i clock-domain-crossing synchroniser
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_NEXT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/vis_prefetch_bank_watch.sv
// ---------------------------------------------------------------------------
// vis_prefetch_bank_watch
// Watches the correlator's active-bank counter from the bus clock domain and
// reports each bank switch.
//   clk_i        bus clock
//   rst_ni       asynchronous active-low reset
//   bank_i       active bank from the correlator clock domain
//   evt_o        1-cycle pulse: a new stable bank value differs from the last
//   bank_prev_o  bank that was active before the switch (the one to drain)
//
// bank_i passes through a 2-FF synchroniser, then must be seen equal on two
// consecutive synchronised samples before it is accepted. The first accepted
// value after reset is only adopted as the reference, so coming out of reset
// never launches a drain.
// ---------------------------------------------------------------------------
module vis_prefetch_bank_watch
  import vis_prefetch_pkg::*;
#(
  parameter int BBITS = DEF_BBITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BBITS-1:0] bank_i,
  output logic             evt_o,
  output logic [BBITS-1:0] bank_prev_o
);

  // Cycles until the synchroniser and the filter register hold real samples
  localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES + 1);

  logic [BBITS-1:0] sync_reg [SYNC_STAGES];
  logic [BBITS-1:0] filt_reg;
  logic [BBITS-1:0] last_reg;
  logic [BBITS-1:0] prev_reg;
  logic [1:0]       fill_reg;
  logic             primed_reg;
  logic             evt_reg;

  logic [BBITS-1:0] samp;
  logic             stable;

  assign samp   = sync_reg[SYNC_STAGES-1];
  // Only trust the comparison once the pipeline has been flushed of reset values
  assign stable = (fill_reg == FILL_DONE) && (samp == filt_reg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
      filt_reg   <= '0;
      last_reg   <= '0;
      prev_reg   <= '0;
      fill_reg   <= '0;
      primed_reg <= 1'b0;
      evt_reg    <= 1'b0;
    end else begin
      sync_reg[0] <= bank_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      filt_reg <= samp;
      if (fill_reg != FILL_DONE) begin
        fill_reg <= fill_reg + 2'd1;
      end

      evt_reg <= 1'b0;
      if (stable) begin
        if (!primed_reg) begin
          // First stable value after reset becomes the reference silently
          primed_reg <= 1'b1;
          last_reg   <= samp;
        end else if (samp != last_reg) begin
          evt_reg  <= 1'b1;
          prev_reg <= last_reg;
          last_reg <= samp;
        end
      end
    end
  end

  assign evt_o       = evt_reg;
  assign bank_prev_o = prev_reg;

endmodule

// File: rtl/vis_prefetch.sv
// ---------------------------------------------------------------------------
// vis_prefetch
// Bus-clock master that drains a completed visibilities bank from one
// correlator block into the SPI readback buffer.
//   clk_i   bus clock            rst_ni  asynchronous active-low reset
//   bank_i  correlator active bank (other clock domain, steps by +1)
//   cyc_o/stb_o/we_o/bst_o/adr_o, ack_i/dat_i   Wishbone-like read port
//   wr_o/wadr_o/wdat_o                           readback buffer write port
//   done_o  1-cycle pulse when a whole bank has been copied
//   ovf_o   sticky: bank switched again while a drain was in progress
//   err_o   sticky: ack_i did not arrive within TMOUT cycles
//   clr_i   clears ovf_o and err_o (a simultaneous set wins)
//
// Each bank switch reads the previous bank word by word, address
// {bank, slot, sel}, and writes word slot*8+sel to the buffer. One read is
// in flight at a time: REQ waits for ack_i, NEXT is a one-cycle gap that
// advances the address.
// ---------------------------------------------------------------------------
module vis_prefetch
  import vis_prefetch_pkg::*;
#(
  parameter int ACCUM = DEF_ACCUM,
  parameter int TRATE = DEF_TRATE,
  parameter int TBITS = DEF_TBITS,
  parameter int BBITS = DEF_BBITS,
  parameter int ABITS = 3 + TBITS + BBITS,
  parameter int WBITS = DEF_WBITS,
  parameter int TMOUT = DEF_TMOUT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BBITS-1:0] bank_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic [ACCUM-1:0] dat_i,
  output logic             wr_o,
  output logic [WBITS-1:0] wadr_o,
  output logic [ACCUM-1:0] wdat_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic             err_o,
  input  logic             clr_i
);

  localparam int                  CBITS     = $clog2(TMOUT + 1);
  localparam logic [CBITS-1:0]    TMO_LAST  = CBITS'(TMOUT - 1);
  localparam logic [TBITS-1:0]    LAST_SLOT = TBITS'(TRATE - 1);
  localparam logic [SEL_BITS-1:0] SEL_LAST  = '1;

  // -------------------------------------------------------------------------
  // Bank switch detection
  // -------------------------------------------------------------------------
  logic             evt;
  logic [BBITS-1:0] watch_prev;

  vis_prefetch_bank_watch #(
    .BBITS (BBITS)
  ) u_bank_watch (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bank_i      (bank_i),
    .evt_o       (evt),
    .bank_prev_o (watch_prev)
  );

  // -------------------------------------------------------------------------
  // Drain state
  // -------------------------------------------------------------------------
  state_t              state_reg;
  logic [BBITS-1:0]    drain_bank_reg;
  logic [BBITS-1:0]    pend_bank_reg;
  logic                pend_reg;
  logic [TBITS-1:0]    slot_reg;
  logic [SEL_BITS-1:0] sel_reg;
  logic [CBITS-1:0]    tmo_reg;
  logic                cyc_reg;
  logic                stb_reg;
  logic                bst_reg;
  logic                wr_reg;
  logic [WBITS-1:0]    wadr_reg;
  logic [ACCUM-1:0]    wdat_reg;
  logic                done_reg;
  logic                ovf_reg;
  logic                err_reg;

  // Address advance: sel counts 0..7, carrying into slot
  logic [SEL_BITS-1:0] sel_next;
  logic [TBITS-1:0]    slot_next;
  logic                last_word;
  logic                next_last;

  assign sel_next  = sel_reg + SEL_BITS'(1);
  assign slot_next = (sel_reg == SEL_LAST) ? slot_reg + TBITS'(1) : slot_reg;
  assign last_word = (slot_reg == LAST_SLOT) && (sel_reg == SEL_LAST);
  assign next_last = (slot_next == LAST_SLOT) && (sel_next == SEL_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      drain_bank_reg <= '0;
      pend_bank_reg  <= '0;
      pend_reg       <= 1'b0;
      slot_reg       <= '0;
      sel_reg        <= '0;
      tmo_reg        <= '0;
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      bst_reg        <= 1'b0;
      wr_reg         <= 1'b0;
      wadr_reg       <= '0;
      wdat_reg       <= '0;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      // Clear first so that any set further down in this block overrides it
      if (clr_i) begin
        ovf_reg <= 1'b0;
        err_reg <= 1'b0;
      end

      wr_reg   <= 1'b0;
      done_reg <= 1'b0;

      // A switch while busy keeps the current drain going and parks the new
      // bank in a single-entry queue; a newer switch simply replaces it.
      if (evt && (state_reg != ST_IDLE)) begin
        ovf_reg       <= 1'b1;
        pend_reg      <= 1'b1;
        pend_bank_reg <= watch_prev;
      end

      case (state_reg)
        ST_IDLE: begin
          if (evt || pend_reg) begin
            drain_bank_reg <= evt ? watch_prev : pend_bank_reg;
            pend_reg       <= 1'b0;
            slot_reg       <= '0;
            sel_reg        <= '0;
            tmo_reg        <= '0;
            cyc_reg        <= 1'b1;
            stb_reg        <= 1'b1;
            // Every slot holds eight words, so word 0 is never the last one
            bst_reg        <= 1'b1;
            state_reg      <= ST_REQ;
          end
        end

        ST_REQ: begin
          // ack_i has priority, so an ack on the timeout cycle is accepted
          if (ack_i) begin
            stb_reg   <= 1'b0;
            wr_reg    <= 1'b1;
            wadr_reg  <= WBITS'({slot_reg, sel_reg});
            wdat_reg  <= dat_i;
            state_reg <= ST_NEXT;
          end else if (tmo_reg == TMO_LAST) begin
            err_reg   <= 1'b1;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            bst_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + CBITS'(1);
          end
        end

        ST_NEXT: begin
          if (last_word) begin
            cyc_reg   <= 1'b0;
            bst_reg   <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            sel_reg   <= sel_next;
            slot_reg  <= slot_next;
            tmo_reg   <= '0;
            stb_reg   <= 1'b1;
            bst_reg   <= !next_last;
            state_reg <= ST_REQ;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cyc_o  = cyc_reg;
  assign stb_o  = stb_reg;
  assign we_o   = 1'b0;
  assign bst_o  = bst_reg;
  assign adr_o  = ABITS'({drain_bank_reg, slot_reg, sel_reg});
  assign wr_o   = wr_reg;
  assign wadr_o = wadr_reg;
  assign wdat_o = wdat_reg;
  assign done_o = done_reg;
  assign ovf_o  = ovf_reg;
  assign err_o  = err_reg;

endmodule

// File: tb/tb_vis_prefetch.sv
// ---------------------------------------------------------------------------
// tb_vis_prefetch
// Bench for the visibilities prefetch master. A behavioural slave serves
// reads from a random memory image with a programmable ack latency; a
// monitor records every request, buffer write, done pulse and error rise
// with a cycle stamp. Expected data for word i of bank b is mem[b*128 + i].
// ---------------------------------------------------------------------------
module tb_vis_prefetch;

  localparam int ACCUM  = 24;
  localparam int TRATE  = 12;
  localparam int TBITS  = 4;
  localparam int BBITS  = 4;
  localparam int ABITS  = 11;
  localparam int WBITS  = 7;
  localparam int TMOUT  = 15;
  localparam int NWORDS = TRATE * 8;

  typedef struct {
    logic [ABITS-1:0] adr;
    logic             bst;
    int               cyc;
  } req_t;

  typedef struct {
    logic [WBITS-1:0] wadr;
    logic [ACCUM-1:0] wdat;
    int               cyc;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [BBITS-1:0] bank_i = '0;
  logic             ack_i = 1'b0;
  logic [ACCUM-1:0] dat_i = '0;
  logic             clr_i = 1'b0;
  logic             cyc_o, stb_o, we_o, bst_o, wr_o, done_o, ovf_o, err_o;
  logic [ABITS-1:0] adr_o;
  logic [WBITS-1:0] wadr_o;
  logic [ACCUM-1:0] wdat_o;

  logic [ACCUM-1:0] mem [0:(1<<ABITS)-1];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int err_cyc  = -1;

  // Slave behaviour knobs
  int fix_lat   = 2;
  bit rand_lat  = 1'b0;
  int force_idx = -1;
  int force_lat = 0;

  req_t req_q[$];
  wr_t  wr_q[$];
  int   done_q[$];

  vis_prefetch #(
    .ACCUM (ACCUM), .TRATE (TRATE), .TBITS (TBITS), .BBITS (BBITS),
    .ABITS (ABITS), .WBITS (WBITS), .TMOUT (TMOUT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bank_i (bank_i),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .we_o   (we_o),
    .bst_o  (bst_o),
    .adr_o  (adr_o),
    .ack_i  (ack_i),
    .dat_i  (dat_i),
    .wr_o   (wr_o),
    .wadr_o (wadr_o),
    .wdat_o (wdat_o),
    .done_o (done_o),
    .ovf_o  (ovf_o),
    .err_o  (err_o),
    .clr_i  (clr_i)
  );

  always #5 clk = ~clk;

  // Slave: acks 'lat' cycles after the strobe is first seen, for one cycle
  initial begin
    int wait_cnt = 0;
    int lat = 0;
    int idx;
    forever begin
      @(negedge clk);
      if (!rst_ni || ack_i) begin
        ack_i = 1'b0;
        wait_cnt = 0;
      end else if (cyc_o && stb_o) begin
        idx = int'(adr_o[6:0]);
        if (wait_cnt == 0)
          lat = (idx == force_idx) ? force_lat : (rand_lat ? int'($urandom_range(0, 3)) : fix_lat);
        if (wait_cnt >= lat) begin
          ack_i = 1'b1;
          dat_i = mem[adr_o];
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    bit stb_prev = 1'b0;
    bit err_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (wr_o) wr_q.push_back('{wadr: wadr_o, wdat: wdat_o, cyc: cyc_cnt});
      if (stb_o && !stb_prev) req_q.push_back('{adr: adr_o, bst: bst_o, cyc: cyc_cnt});
      if (done_o) done_q.push_back(cyc_cnt);
      if (err_o && !err_prev) err_cyc = cyc_cnt;
      stb_prev = stb_o;
      err_prev = err_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_capture();
    req_q.delete();
    wr_q.delete();
    done_q.delete();
    err_cyc = -1;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int c = 0;
    while (done_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int c = 0;
    while (wr_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (wr_q.size() >= n);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_i = 1'b1;
    @(negedge clk); clr_i = 1'b0;
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni = 1'b0;
    bank_i = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({cyc_o, stb_o, we_o, bst_o} !== 4'b0) $display("FAIL reset_bus got %b want 0000", {cyc_o, stb_o, we_o, bst_o}); else n_pass++;
    n_checks++; if ({wr_o, done_o, ovf_o, err_o} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {wr_o, done_o, ovf_o, err_o}); else n_pass++;
    n_checks++; if (adr_o !== '0) $display("FAIL reset_adr got %h want 0", adr_o); else n_pass++;
    n_checks++; if ({wadr_o, wdat_o} !== '0) $display("FAIL reset_wbuf got %h/%h want 0/0", wadr_o, wdat_o); else n_pass++;
    rst_ni = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (req_q.size() !== 0 || cyc_o !== 1'b0) $display("FAIL reset_no_drain got %0d requests cyc %b want 0 0", req_q.size(), cyc_o); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_drain();
    bit ok;
    clear_capture();
    rand_lat = 1'b0;
    fix_lat  = 2;
    bank_i   = 4'd1;
    wait_done(1, 3000, ok);
    repeat (4) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL t1_done_timeout got no done want done"); else n_pass++;
    $display("drain bank 0: %0d writes, %0d done cycles", wr_q.size(), done_q.size());
    n_checks++; if (wr_q.size() !== NWORDS) $display("FAIL t1_wr_count got %0d want %0d", wr_q.size(), NWORDS); else n_pass++;
    n_checks++; if (req_q.size() !== NWORDS) $display("FAIL t1_req_count got %0d want %0d", req_q.size(), NWORDS); else n_pass++;
    if (wr_q.size() == NWORDS && req_q.size() == NWORDS) begin
      for (int i = 0; i < NWORDS; i++) begin
        n_checks++;
        if (wr_q[i].wadr !== WBITS'(i) || wr_q[i].wdat !== mem[0*128 + i])
          $display("FAIL t1_word%0d got %0d/%h want %0d/%h", i, wr_q[i].wadr, wr_q[i].wdat, i, mem[0*128 + i]);
        else n_pass++;
        n_checks++;
        if (req_q[i].adr !== ABITS'(0*128 + i) || req_q[i].bst !== (i != NWORDS-1))
          $display("FAIL t1_req%0d got adr %h bst %b want %h %b", i, req_q[i].adr, req_q[i].bst, 0*128 + i, i != NWORDS-1);
        else n_pass++;
      end
      n_checks++;
      if (wr_q[NWORDS-1].cyc - wr_q[0].cyc !== (NWORDS-1) * 4)
        $display("FAIL t1_rate got %0d want %0d", wr_q[NWORDS-1].cyc - wr_q[0].cyc, (NWORDS-1) * 4);
      else n_pass++;
    end
    n_checks++; if (done_q.size() !== 1) $display("FAIL t1_done_pulse got %0d cycles want 1", done_q.size()); else n_pass++;
    n_checks++; if ({ovf_o, err_o, cyc_o} !== 3'b000) $display("FAIL t1_flags got %b want 000", {ovf_o, err_o, cyc_o}); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_glitch();
    clear_capture();
    @(negedge clk); bank_i = 4'd3;
    @(negedge clk); bank_i = 4'd1;
    repeat (20) @(negedge clk);
    $display("glitch 1->3->1: %0d requests", req_q.size());
    n_checks++; if (req_q.size() !== 0 || cyc_o !== 1'b0) $display("FAIL t2_glitch got %0d requests cyc %b want 0 0", req_q.size(), cyc_o); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overflow();
    bit ok;
    clear_capture();
    rand_lat = 1'b1;
    bank_i   = 4'd2;
    wait_writes(40, 2000, ok);
    n_checks++; if (!ok) $display("FAIL t3_first40 got %0d writes want 40", wr_q.size()); else n_pass++;
    bank_i = 4'd3;
    repeat (10) @(negedge clk);
    n_checks++; if ({ovf_o, cyc_o} !== 2'b11) $display("FAIL t3_ovf_set got ovf %b cyc %b want 1 1", ovf_o, cyc_o); else n_pass++;
    wait_done(2, 5000, ok);
    repeat (4) @(negedge clk);
    n_checks++; if (!ok) $display("FAIL t3_done_timeout got %0d dones want 2", done_q.size()); else n_pass++;
    $display("drain bank 1 + queued bank 2: %0d writes, %0d done cycles", wr_q.size(), done_q.size());
    n_checks++; if (wr_q.size() !== 2*NWORDS) $display("FAIL t3_wr_count got %0d want %0d", wr_q.size(), 2*NWORDS); else n_pass++;
    if (wr_q.size() == 2*NWORDS) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NWORDS; i++) begin
          n_checks++;
          if (wr_q[d*NWORDS + i].wadr !== WBITS'(i) || wr_q[d*NWORDS + i].wdat !== mem[(d+1)*128 + i])
            $display("FAIL t3_bank%0d_word%0d got %0d/%h want %0d/%h", d+1, i, wr_q[d*NWORDS + i].wadr, wr_q[d*NWORDS + i].wdat, i, mem[(d+1)*128 + i]);
          else n_pass++;
        end
      end
    end
    n_checks++; if (done_q.size() !== 2) $display("FAIL t3_done_count got %0d want 2", done_q.size()); else n_pass++;
    if (done_q.size() >= 1 && req_q.size() > NWORDS) begin
      n_checks++;
      if (req_q[NWORDS].cyc - done_q[0] !== 2 || req_q[NWORDS].adr[10:7] !== 4'd2)
        $display("FAIL t3_restart got gap %0d bank %0d want 2 2", req_q[NWORDS].cyc - done_q[0], req_q[NWORDS].adr[10:7]);
      else n_pass++;
    end
    n_checks++; if (err_o !== 1'b0) $display("FAIL t3_err got %b want 0", err_o); else n_pass++;
    pulse_clr();
    n_checks++; if (ovf_o !== 1'b0) $display("FAIL t3_ovf_clr got %b want 0", ovf_o); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timeout();
    int c = 0;
    clear_capture();
    rand_lat  = 1'b0;
    fix_lat   = 1;
    force_idx = 10;
    force_lat = 1000;
    bank_i    = 4'd4;
    while (!err_o && c < 2000) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (err_o !== 1'b1) $display("FAIL t4_err_set got %b want 1", err_o); else n_pass++;
    repeat (2) @(negedge clk);
    if (req_q.size() >= 11) begin
      n_checks++;
      if (err_cyc - req_q[10].cyc !== TMOUT) $display("FAIL t4_err_delay got %0d want %0d", err_cyc - req_q[10].cyc, TMOUT); else n_pass++;
    end
    n_checks++; if ({cyc_o, stb_o} !== 2'b00) $display("FAIL t4_bus_drop got %b want 00", {cyc_o, stb_o}); else n_pass++;
    repeat (30) @(negedge clk);
    $display("timeout on word 10 of bank 3: %0d writes, %0d requests", wr_q.size(), req_q.size());
    n_checks++; if (wr_q.size() !== 10 || req_q.size() !== 11) $display("FAIL t4_stopped got %0d writes %0d reqs want 10 11", wr_q.size(), req_q.size()); else n_pass++;
    n_checks++; if (done_q.size() !== 0) $display("FAIL t4_no_done got %0d want 0", done_q.size()); else n_pass++;
    force_idx = -1;
    pulse_clr();
    n_checks++; if (err_o !== 1'b0) $display("FAIL t4_err_clr got %b want 0", err_o); else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    bit ok;
    clear_capture();
    rand_lat  = 1'b1;
    force_idx = 5;
    force_lat = TMOUT - 1;   // ack lands exactly on the timeout edge
    bank_i    = 4'd15;
    wait_done(1, 5000, ok);
    repeat (3) @(negedge clk);
    force_idx = -1;
    $display("drain bank 4 (late ack on word 5): %0d writes", wr_q.size());
    n_checks++; if (!ok || wr_q.size() !== NWORDS) $display("FAIL t5_late_ack_drain got %0d writes want %0d", wr_q.size(), NWORDS); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL t5_late_ack_err got %b want 0", err_o); else n_pass++;
    if (wr_q.size() > 5 && req_q.size() > 5) begin
      n_checks++;
      if (wr_q[5].cyc - req_q[5].cyc !== TMOUT || wr_q[5].wdat !== mem[4*128 + 5])
        $display("FAIL t5_late_ack_word got delay %0d dat %h want %0d %h", wr_q[5].cyc - req_q[5].cyc, wr_q[5].wdat, TMOUT, mem[4*128 + 5]);
      else n_pass++;
    end

    clear_capture();
    bank_i = 4'd0;
    wait_done(1, 5000, ok);
    repeat (3) @(negedge clk);
    $display("drain bank 15 (wrap): %0d writes", wr_q.size());
    n_checks++; if (!ok || wr_q.size() !== NWORDS || req_q.size() !== NWORDS) $display("FAIL t5_wrap_count got %0d/%0d want %0d", wr_q.size(), req_q.size(), NWORDS); else n_pass++;
    if (wr_q.size() == NWORDS && req_q.size() == NWORDS) begin
      for (int i = 0; i < NWORDS; i++) begin
        n_checks++;
        if (req_q[i].adr[10:7] !== 4'd15 || wr_q[i].wdat !== mem[15*128 + i])
          $display("FAIL t5_wrap_word%0d got bank %0d dat %h want 15 %h", i, req_q[i].adr[10:7], wr_q[i].wdat, mem[15*128 + i]);
        else n_pass++;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_drain();
    bit ok;
    clear_capture();
    rand_lat = 1'b0;
    fix_lat  = 1;
    bank_i   = 4'd1;
    wait_writes(20, 2000, ok);
    n_checks++; if (!ok || cyc_o !== 1'b1) $display("FAIL t6_midway got %0d writes cyc %b want 20 1", wr_q.size(), cyc_o); else n_pass++;
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if ({cyc_o, stb_o, wr_o} !== 3'b000) $display("FAIL t6_async_abort got %b want 000", {cyc_o, stb_o, wr_o}); else n_pass++;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    clear_capture();
    repeat (40) @(negedge clk);
    $display("reset mid-drain: %0d requests after release", req_q.size());
    n_checks++; if (req_q.size() !== 0 || done_q.size() !== 0 || cyc_o !== 1'b0) $display("FAIL t6_quiet got %0d reqs %0d dones want 0 0", req_q.size(), done_q.size()); else n_pass++;
    bank_i = 4'd2;
    wait_done(1, 3000, ok);
    repeat (3) @(negedge clk);
    $display("drain bank 1 after reset: %0d writes", wr_q.size());
    n_checks++; if (!ok || wr_q.size() !== NWORDS) $display("FAIL t6_redrain got %0d writes want %0d", wr_q.size(), NWORDS); else n_pass++;
    if (req_q.size() > 0 && wr_q.size() > 0) begin
      n_checks++;
      if (req_q[0].adr[10:7] !== 4'd1 || wr_q[0].wdat !== mem[1*128])
        $display("FAIL t6_redrain_bank got %0d/%h want 1/%h", req_q[0].adr[10:7], wr_q[0].wdat, mem[1*128]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << ABITS); a++) mem[a] = ACCUM'($urandom());
    test_reset();
    test_single_drain();
    test_glitch();
    test_overflow();
    test_timeout();
    test_wrap();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
